// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: multi-cycle MEM-stage access controller.
// It sits between EX/MEM and MEM/WB and runs loads and stores against RAM1
// (asynchronous SRAM) and the memory-mapped UART over a shared data bus.
// Build option: define UART_TX_WAIT_EN to make UART_WR1 wait for the
// transmitter (tbre & tsre) before it pulses wrn. When the macro is not
// defined, software must poll the status register before each write.
//
// Handshake: mem_stall is the only flow control. While mem_stall is high, the
// request on mem_read/mem_write/address/data_in must stay stable. A request
// is consumed on the first rising edge where mem_stall is low. That edge is
// either the single status-access cycle or the DONE cycle. A new request is
// decoded only in IDLE.
module mem_stage_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter logic [1:0]  RAM_ADDR_HI    = 2'b00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [15:0] address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        mem_stall,
  output logic        ram1_en,
  output logic        ram1_oe,
  output logic        ram1_we,
  output logic [17:0] ram1_addr,
  inout  wire  [15:0] ram1_data,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre,
  output logic        rdn,
  output logic        wrn,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RAM_RD,
    S_RAM_WR1,
    S_RAM_WR2,
    S_UART_RD1,
    S_UART_RD2,
    S_UART_WR1,
    S_UART_WR2,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        is_store;
  logic        is_load;
  logic        hit_uart;
  logic        hit_stat;
  logic        multi_req;
  logic        wr_q;       // the access now in flight is a write
  logic [15:0] wdata_q;    // store data, held on the bus through DONE
  logic        stall_c;
  logic        bus_drive;

  // Request and target decode. A store takes priority when both flags are set.
  assign is_store  = (mem_write != 2'b00);
  assign is_load   = !is_store && (mem_read != 2'b00);
  assign hit_uart  = (address == UART_DATA_ADDR);
  assign hit_stat  = (address == UART_STAT_ADDR);
  // Status accesses finish in one cycle. Every other request needs the FSM.
  assign multi_req = (is_store || is_load) && !hit_stat;

  assign ram1_addr = {RAM_ADDR_HI, address};
  assign ram1_data = bus_drive ? wdata_q : 16'hzzzz;
  // Stall is forced low while reset is held, so that the pipeline is not
  // frozen by a request that happens to be present during reset.
  assign mem_stall = stall_c && !RST;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Each access walks a fixed path that ends in DONE.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (is_store && !hit_stat) begin
          state_next = hit_uart ? S_UART_WR1 : S_RAM_WR1;
        end else if (is_load && !hit_stat) begin
          state_next = hit_uart ? S_UART_RD1 : S_RAM_RD;
        end
      end
      S_RAM_RD:   state_next = S_DONE;
      S_RAM_WR1:  state_next = S_RAM_WR2;
      S_RAM_WR2:  state_next = S_DONE;
      S_UART_RD1: state_next = S_UART_RD2;
      S_UART_RD2: state_next = S_DONE;
`ifdef UART_TX_WAIT_EN
      S_UART_WR1: state_next = (tbre && tsre) ? S_UART_WR2 : S_UART_WR1;
`else
      S_UART_WR1: state_next = S_UART_WR2;
`endif
      S_UART_WR2: state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Strobe, bus-enable and stall decode. All strobes are active low.
  // ram1_en is low only in RAM states, so rdn and wrn can never be low at the same time as ram1_en.
  always_comb begin
    ram1_en   = 1'b1;
    ram1_oe   = 1'b1;
    ram1_we   = 1'b1;
    rdn       = 1'b1;
    wrn       = 1'b1;
    bus_drive = 1'b0;
    stall_c   = 1'b0;
    case (state)
      S_IDLE: stall_c = multi_req;
      S_RAM_RD: begin
        ram1_en = 1'b0;
        ram1_oe = 1'b0;
        stall_c = 1'b1;
      end
      S_RAM_WR1: begin
        ram1_en   = 1'b0;
        bus_drive = 1'b1;
        stall_c   = 1'b1;
      end
      S_RAM_WR2: begin
        ram1_en   = 1'b0;
        ram1_we   = 1'b0;
        bus_drive = 1'b1;
        stall_c   = 1'b1;
      end
      S_UART_RD1, S_UART_RD2: begin
        rdn     = 1'b0;
        stall_c = 1'b1;
      end
      S_UART_WR1: begin
        bus_drive = 1'b1;
        stall_c   = 1'b1;
      end
      S_UART_WR2: begin
        wrn       = 1'b0;
        bus_drive = 1'b1;
        stall_c   = 1'b1;
      end
      // After a write, the bus keeps driving for one more cycle as data hold time.
      S_DONE:  bus_drive = wr_q;
      default: stall_c = 1'b0;
    endcase
  end

  // Capture the access type and store data when the FSM leaves IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_q    <= 1'b0;
      wdata_q <= 16'h0000;
    end else if (state == S_IDLE && multi_req) begin
      wr_q    <= is_store;
      wdata_q <= data_in;
    end
  end

  // Load result register. It holds its value unless a load completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_out <= 16'h0000;
    end else if (state == S_RAM_RD) begin
      data_out <= ram1_data;
    end else if (state == S_UART_RD2) begin
      data_out <= {8'h00, ram1_data[7:0]};
    end else if (state == S_IDLE && is_load && hit_stat) begin
      data_out <= {14'b0, data_ready, tbre & tsre};
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized self-checking bench for mem_stage_ctrl.
// A board model provides a 16-word SRAM (decoded on the low address nibble)
// and a UART receive byte on the shared bus. Each driver task works at the
// transaction level: it turns one pipeline request into the expected
// bus/strobe/stall picture for each cycle, following the access rules, and
// queues that picture. A single compare process checks every cycle against
// that queue.
module tb_mem_stage_ctrl;
  localparam int W = 40;
  localparam logic [1:0] BZ = 2'd0;  // bus released (reads as pull-up)
  localparam logic [1:0] BV = 2'd1;  // bus driven by the controller with a value
  localparam logic [1:0] BX = 2'd2;  // bus driven by the board; not checked

  // clock / reset
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  always #5 CLK = ~CLK;

  logic [1:0]  mem_read, mem_write;
  logic [15:0] address, data_in, data_out;
  logic        mem_stall, ram1_en, ram1_oe, ram1_we, rdn, wrn;
  logic        data_ready, tbre, tsre;
  logic [17:0] ram1_addr;
  logic [3:0]  dbg_state;
  tri1  [15:0] ram1_data;

  mem_stage_ctrl dut (
    .CLK(CLK), .RST(RST), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .data_in(data_in), .data_out(data_out),
    .mem_stall(mem_stall), .ram1_en(ram1_en), .ram1_oe(ram1_oe),
    .ram1_we(ram1_we), .ram1_addr(ram1_addr), .ram1_data(ram1_data),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .rdn(rdn), .wrn(wrn),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur;
  logic [15:0]  model_dout;
  logic [15:0]  ref_mem [16];

  // Board: SRAM and UART receive data on the shared bus
  logic [15:0] sram [16];
  logic [7:0]  uart_rx, uart_hi;
  logic [7:0]  uart_tx_last = 8'h00;
  logic        board_en;
  logic [15:0] board_drv;
  assign board_en  = (!ram1_en && !ram1_oe) || !rdn;
  assign board_drv = !rdn ? {uart_hi, uart_rx} : sram[ram1_addr[3:0]];
  assign ram1_data = board_en ? board_drv : 16'hzzzz;

  function automatic logic [15:0] init_val(input int i);
    return 16'hC000 + 16'(i) * 16'h0101;
  endfunction

  always @(negedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) sram[i] = init_val(i);
    end else begin
      if (!ram1_en && !ram1_we) sram[ram1_addr[3:0]] = ram1_data;
      if (!wrn) uart_tx_last = ram1_data[7:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Each expected-cycle record holds: stall, en, oe, we, rdn, wrn, bus mode, bus value, data_out.
  function automatic logic [W-1:0] rec(input logic st, input logic en, input logic oe,
                                       input logic we, input logic rd, input logic wr,
                                       input logic [1:0] bm, input logic [15:0] bv,
                                       input logic [15:0] dout);
    return {st, en, oe, we, rd, wr, bm, bv, dout};
  endfunction

  // Scoreboard: checks every cycle that has an expectation.
  int we_low_n = 0;
  int rdn_low_n = 0;
  int wrn_low_n = 0;
  always @(negedge CLK) begin
    if (!ram1_we) we_low_n++;
    if (!rdn) rdn_low_n++;
    if (!wrn) wrn_low_n++;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("mem_stall", 32'(mem_stall), 32'(cur[39]));
      chk("ram1_en",   32'(ram1_en),   32'(cur[38]));
      chk("ram1_oe",   32'(ram1_oe),   32'(cur[37]));
      chk("ram1_we",   32'(ram1_we),   32'(cur[36]));
      chk("rdn",       32'(rdn),       32'(cur[35]));
      chk("wrn",       32'(wrn),       32'(cur[34]));
      if (cur[33:32] == BZ) chk("bus_released", 32'(ram1_data), 32'h0000FFFF);
      if (cur[33:32] == BV) chk("bus_value", 32'(ram1_data), 32'(cur[31:16]));
      chk("data_out",  32'(data_out),  32'(cur[15:0]));
      chk("ram1_addr", 32'(ram1_addr), 32'({2'b00, address}));
      chk("strobe_excl", 32'(ram1_en | (rdn & wrn)), 32'h1);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input logic [W-1:0] r);
    exp_q.push_back(r);
    tick();
  endtask

  task automatic op_idle();
    mem_read = 2'b00; mem_write = 2'b00; address = 16'($urandom);
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
  endtask

  task automatic op_ram_load(input logic [15:0] a);
    mem_read = 2'($urandom_range(1, 3)); mem_write = 2'b00; address = a;
    data_in = 16'($urandom);
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
    step(rec(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BX, 16'h0, model_dout));
    model_dout = ref_mem[a[3:0]];
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
  endtask

  // If both is set, the read flag is also raised; the access must still act as a store.
  task automatic op_ram_store(input logic [15:0] a, input logic [15:0] d, input logic both);
    mem_write = 2'($urandom_range(1, 3));
    mem_read = both ? 2'($urandom_range(1, 3)) : 2'b00;
    address = a; data_in = d;
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
    step(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BV, d, model_dout));
    step(rec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, BV, d, model_dout));
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BV, d, model_dout));
    ref_mem[a[3:0]] = d;
  endtask

  task automatic op_uart_load(input logic [7:0] rx, input logic [7:0] hi);
    mem_read = 2'($urandom_range(1, 3)); mem_write = 2'b00; address = 16'hBF00;
    uart_rx = rx; uart_hi = hi;
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BX, 16'h0, model_dout));
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BX, 16'h0, model_dout));
    model_dout = {8'h00, rx};
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
  endtask

  // wait_n is the number of cycles the transmitter reports busy during UART_WR1.
  task automatic op_uart_store(input logic [15:0] d, input int wait_n);
    mem_write = 2'($urandom_range(1, 3)); mem_read = 2'b00; address = 16'hBF00;
    data_in = d;
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
`ifdef UART_TX_WAIT_EN
    for (int i = 0; i < wait_n; i++) begin
      tbre = 1'b0; tsre = 1'($urandom_range(0, 1));
      step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BV, d, model_dout));
    end
    tbre = 1'b1; tsre = 1'b1;
`else
    tbre = (wait_n == 0); tsre = 1'($urandom_range(0, 1));
`endif
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BV, d, model_dout));
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, BV, d, model_dout));
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BV, d, model_dout));
  endtask

  task automatic op_status_load(input logic dr, input logic tb, input logic ts);
    mem_read = 2'($urandom_range(1, 3)); mem_write = 2'b00; address = 16'hBF01;
    data_ready = dr; tbre = tb; tsre = ts;
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
    model_dout = {14'b0, dr, tb & ts};
  endtask

  task automatic op_status_store();
    mem_write = 2'($urandom_range(1, 3)); mem_read = 2'($urandom_range(0, 3));
    address = 16'hBF01; data_in = 16'($urandom);
    step(rec(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
  endtask

  function automatic logic [15:0] rand_ram_addr();
    logic [15:0] a;
    a = 16'($urandom_range(0, 65535));
    if (a == 16'hBF00 || a == 16'hBF01) a = 16'h4000;
    return a;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  int k;
  int snap;
  initial begin
    mem_read = 2'b00; mem_write = 2'b00; address = 16'h0; data_in = 16'h0;
    data_ready = 1'b0; tbre = 1'b1; tsre = 1'b1; uart_rx = 8'h00; uart_hi = 8'h00;
    model_dout = 16'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    #2 RST = 1'b1;
    repeat (3) tick();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_strobes", 32'({ram1_en, ram1_oe, ram1_we, rdn, wrn}), 32'h1F);
    chk("rst_bus", 32'(ram1_data), 32'h0000FFFF);
    RST = 1'b0;
    op_idle();
    op_idle();

    // RAM store followed by a load from the same address.
    snap = we_low_n;
    op_ram_store(16'h4000, 16'hA5C3, 1'b0);
    chk("ram_addr_lit", 32'(ram1_addr), 32'h00004000);
    chk("we_low_cycles", 32'(we_low_n - snap), 32'd1);
    op_ram_load(16'h4000);
    chk("ram_load_lit", 32'(data_out), 32'h0000A5C3);

    // UART load returns the receive byte, zero-extended.
    data_ready = 1'b1;
    snap = rdn_low_n;
    op_uart_load(8'h5A, 8'hE7);
    chk("uart_load_lit", 32'(data_out), 32'h0000005A);
    chk("rdn_low_cycles", 32'(rdn_low_n - snap), 32'd2);

    // Status load: one cycle, and the result is visible in the next cycle.
    op_status_load(1'b1, 1'b1, 1'b0);
    op_idle();
    chk("status_lit", 32'(data_out), 32'h00000002);

    // Back-to-back store and load, then a read back of the stored value.
    op_ram_store(16'h4003, 16'h1234, 1'b0);
    op_ram_load(16'h4005);
    op_ram_load(16'h4003);
    chk("b2b_lit", 32'(data_out), 32'h00001234);

    // UART store while the transmitter is busy for five cycles.
    snap = wrn_low_n;
    op_uart_store(16'h0041, 5);
    chk("uart_tx_byte", 32'(uart_tx_last), 32'h41);
    chk("wrn_low_cycles", 32'(wrn_low_n - snap), 32'd1);
    op_idle();

    // Reset asserted in the middle of a RAM write (during RAM_WR2).
    mem_write = 2'b01; mem_read = 2'b00; address = 16'h7777; data_in = 16'h1357;
    step(rec(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, BZ, 16'h0, model_dout));
    step(rec(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, BV, 16'h1357, model_dout));
    chk("we_before_rst", 32'(ram1_we), 32'h0);
    RST = 1'b1;
    #1;
    chk("midrst_strobes", 32'({ram1_en, ram1_oe, ram1_we}), 32'h7);
    chk("midrst_data_out", 32'(data_out), 32'h0);
    chk("midrst_bus", 32'(ram1_data), 32'h0000FFFF);
    chk("midrst_stall", 32'(mem_stall), 32'h0);
    mem_write = 2'b00;
    tick();
    tick();
    RST = 1'b0;
    model_dout = 16'h0;
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    op_idle();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: op_ram_load(rand_ram_addr());
        1: op_ram_store(rand_ram_addr(), 16'($urandom), 1'b0);
        2: op_uart_load(8'($urandom), 8'($urandom));
        3: op_uart_store(16'($urandom), $urandom_range(0, 3));
        4: op_status_load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        5: op_status_store();
        6: op_idle();
        default: op_ram_store(rand_ram_addr(), 16'($urandom), 1'b1);
      endcase
    end
    op_idle();
    op_idle();
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
